// File: rtl/uart_parity_unit.sv
// uart_parity_unit: shared parity engine for the UART datapath.
// TX half: captures a parallel word and registers its parity bit.
// RX half: accumulates parity from the serial data bits, checks the received
// parity bit and reports per-frame errors plus a sticky error flag.
//
// Handshake: every *_valid input is a single-cycle strobe. There is no ready
// signal, so a strobe is consumed on the rising edge that samples it, and
// back-to-back strobes on consecutive cycles are all accepted. Outputs
// par_valid, par_err and frame_err are one-cycle pulses registered after
// the edge that sampled the causing strobe.
module uart_parity_unit #(
  parameter int DATA_WIDTH = 8,
  localparam int LEN_W = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  PAR_EN,
  input  logic [1:0]            PAR_TYP,
  input  logic [LEN_W-1:0]      DATA_LEN,
  input  logic                  Data_Valid,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  par_bit,
  output logic                  par_valid,
  input  logic                  rx_start,
  input  logic                  rx_bit_valid,
  input  logic                  rx_bit,
  input  logic                  rx_par_valid,
  input  logic                  rx_par_bit,
  input  logic                  err_clr,
  output logic                  rx_busy,
  output logic                  par_err,
  output logic                  frame_err,
  output logic                  par_err_sticky,
  output logic [1:0]            rx_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_PAR  = 2'd2
  } rx_state_t;

  localparam logic [1:0] TYP_ODD   = 2'b00;
  localparam logic [1:0] TYP_EVEN  = 2'b01;
  localparam logic [1:0] TYP_MARK  = 2'b10;

  // 0 or anything above DATA_WIDTH selects the full word.
  function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
    if (len == '0 || len > LEN_W'(DATA_WIDTH)) return LEN_W'(DATA_WIDTH);
    else return len;
  endfunction

  // Parity bit from the XOR-reduction of the data and the parity mode.
  function automatic logic par_fn(input logic red, input logic [1:0] typ);
    case (typ)
      TYP_ODD:  return ~red;
      TYP_EVEN: return red;
      TYP_MARK: return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

  // ---------------- TX half ----------------
  logic [LEN_W-1:0]      tx_len;
  logic [DATA_WIDTH-1:0] tx_masked;
  logic                  tx_par;

  // Mask bits beyond the effective length, then reduce to a parity bit.
  always_comb begin
    tx_len    = eff_len(DATA_LEN);
    tx_masked = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      tx_masked[i] = P_DATA[i] & (i < int'(tx_len));
    end
    tx_par = par_fn(^tx_masked, PAR_TYP);
  end

  // Register the TX parity bit and its one-cycle update pulse.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      par_bit   <= 1'b0;
      par_valid <= 1'b0;
    end else if (Data_Valid) begin
      par_bit   <= PAR_EN ? tx_par : 1'b0;
      par_valid <= PAR_EN;
    end else begin
      par_valid <= 1'b0;
    end
  end

  // ---------------- RX half ----------------
  rx_state_t        state, state_n;
  logic             acc, acc_n;
  logic [LEN_W-1:0] cnt, cnt_n;
  logic [LEN_W-1:0] lat_len, lat_len_n;
  logic             lat_en, lat_en_n;
  logic [1:0]       lat_typ, lat_typ_n;
  logic             par_err_d, frame_err_d;

  // RX next-state logic; rx_start restarts the frame from any state.
  always_comb begin
    state_n     = state;
    acc_n       = acc;
    cnt_n       = cnt;
    lat_len_n   = lat_len;
    lat_en_n    = lat_en;
    lat_typ_n   = lat_typ;
    par_err_d   = 1'b0;
    frame_err_d = 1'b0;
    if (rx_start) begin
      state_n   = S_DATA;
      acc_n     = 1'b0;
      cnt_n     = '0;
      lat_len_n = eff_len(DATA_LEN);
      lat_en_n  = PAR_EN;
      lat_typ_n = PAR_TYP;
    end else begin
      case (state)
        S_DATA: begin
          if (rx_par_valid) begin
            // Parity arrived before all data bits: short frame.
            frame_err_d = 1'b1;
            state_n     = S_IDLE;
          end else if (rx_bit_valid) begin
            acc_n = acc ^ rx_bit;
            cnt_n = cnt + LEN_W'(1);
            if (cnt_n == lat_len) state_n = lat_en ? S_PAR : S_IDLE;
          end
        end
        S_PAR: begin
          if (rx_par_valid) begin
            par_err_d = (rx_par_bit != par_fn(acc, lat_typ));
            state_n   = S_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  // RX state, accumulator, counter, latched config and error pulses.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state     <= S_IDLE;
      acc       <= 1'b0;
      cnt       <= '0;
      lat_len   <= '0;
      lat_en    <= 1'b0;
      lat_typ   <= 2'b00;
      par_err   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      acc       <= acc_n;
      cnt       <= cnt_n;
      lat_len   <= lat_len_n;
      lat_en    <= lat_en_n;
      lat_typ   <= lat_typ_n;
      par_err   <= par_err_d;
      frame_err <= frame_err_d;
    end
  end

  // Sticky error: a new error wins over a same-cycle clear.
  always_ff @(posedge CLK) begin
    if (!RST) par_err_sticky <= 1'b0;
    else if (par_err_d || frame_err_d) par_err_sticky <= 1'b1;
    else if (err_clr) par_err_sticky <= 1'b0;
  end

  assign rx_busy  = (state != S_IDLE);
  assign rx_state = state;

endmodule
